// File: rtl/common.sv
// rtl/common.sv - shared fetch widths, NOOP encoding and prefetch defaults
package common;

    localparam int PROGRAM_ADDRESS_WIDTH = 32;
    localparam int INSTRUCTION_WIDTH     = 32;
    localparam logic [INSTRUCTION_WIDTH-1:0] NOOP = 32'h0000_0013;

    localparam int FETCH_DEPTH           = 4;
    localparam int FETCH_MAX_OUTSTANDING = 2;

    // A halfword starts a 32-bit instruction when its two low bits are both set
    function automatic logic is_full_width(input logic [15:0] half);
        return half[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/instruction_prefetch_if.sv
// rtl/instruction_prefetch_if.sv - memory, redirect and decode-side signals of the prefetch stage
interface instruction_prefetch_if;
    import common::*;

    logic                             redirect_valid;
    logic [PROGRAM_ADDRESS_WIDTH-1:0] redirect_pc;
    logic                             mem_req_valid;
    logic                             mem_req_ready;
    logic [PROGRAM_ADDRESS_WIDTH-1:0] mem_req_addr;
    logic                             mem_rsp_valid;
    logic [INSTRUCTION_WIDTH-1:0]     mem_rsp_data;
    logic                             instr_valid;
    logic                             instr_ready;
    logic [INSTRUCTION_WIDTH-1:0]     instruction;
    logic [PROGRAM_ADDRESS_WIDTH-1:0] o_pc;
    logic                             instr_compressed;

    // Prefetch stage side
    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
        output mem_req_valid, mem_req_addr, instr_valid, instruction, o_pc, instr_compressed
    );

    // Memory and decode side
    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
        input  mem_req_valid, mem_req_addr, instr_valid, instruction, o_pc, instr_compressed
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH x 32 circular word buffer exposing head, head+1 and count
module fetch_fifo
    import common::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [INSTRUCTION_WIDTH-1:0] push_data,
    input  logic                         pop,
    output logic [INSTRUCTION_WIDTH-1:0] head,
    output logic [INSTRUCTION_WIDTH-1:0] head_next,
    output logic [CW-1:0]                count
);

    logic [INSTRUCTION_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]                rd_ptr;
    logic [AW-1:0]                wr_ptr;
    logic                         do_push;
    logic                         do_pop;

    // A push into a full buffer is only taken when a pop frees the head slot in the same cycle
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + AW'(1)];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Word storage; contents are only meaningful below count so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instruction_prefetch.sv
// rtl/instruction_prefetch.sv - in-order word prefetch with queue and aligner; COMPRESSED_EN adds 16-bit support
module instruction_prefetch
    import common::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
    parameter logic [PROGRAM_ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    instruction_prefetch_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = PROGRAM_ADDRESS_WIDTH;

    logic [AW-1:0]                fetch_addr;
    logic [AW-1:0]                pc;
    logic [AW-1:0]                redirect_target;
    logic [AW-1:0]                pc_step;
    logic [CW-1:0]                outstanding;
    logic [CW-1:0]                discard;
    logic [CW-1:0]                count;
    logic [CW:0]                  in_flight;
    logic [INSTRUCTION_WIDTH-1:0] head;
    logic [INSTRUCTION_WIDTH-1:0] head_next;
    logic [INSTRUCTION_WIDTH-1:0] word;
    logic                         req_fire;
    logic                         rsp_push;
    logic                         consume;
    logic                         pop;
    logic                         avail;
    logic                         cmp;

    // Words queued plus words still owed by memory never exceed DEPTH, so a push cannot overflow
    assign in_flight         = {1'b0, outstanding} + {1'b0, count};
    assign bus.mem_req_valid = rst && (outstanding < CW'(MAX_OUTSTANDING))
                               && (in_flight < (CW+1)'(DEPTH));
    assign bus.mem_req_addr  = fetch_addr;
    assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;

    assign rsp_push = bus.mem_rsp_valid && (discard == '0) && !bus.redirect_valid;
    assign consume  = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.redirect_valid),
        .push      (rsp_push),
        .push_data (bus.mem_rsp_data),
        .pop       (pop),
        .head      (head),
        .head_next (head_next),
        .count     (count)
    );

`ifdef COMPRESSED_EN
    logic        hp;
    logic [15:0] low_half;
    logic        full_width;
    logic        unused_redirect_bit;

    assign low_half            = hp ? head[31:16] : head[15:0];
    assign full_width          = is_full_width(low_half);
    assign unused_redirect_bit = bus.redirect_pc[0];

    // Pick 16-bit, aligned 32-bit or straddling 32-bit and require every half it needs
    always_comb begin
        avail = 1'b0;
        cmp   = 1'b0;
        word  = head;
        if (!full_width) begin
            avail = count != '0;
            cmp   = 1'b1;
            word  = {16'h0000, low_half};
        end else if (!hp) begin
            avail = count != '0;
        end else begin
            avail = count >= CW'(2);
            word  = {head_next[15:0], head[31:16]};
        end
    end

    // The head word is used up by any 32-bit instruction or by a 16-bit one in its upper half
    assign pop             = consume && (full_width || hp);
    assign redirect_target = {bus.redirect_pc[AW-1:1], 1'b0};
    assign pc_step         = cmp ? AW'(2) : AW'(4);

    // Halfword pointer into the head word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hp <= RESET_PC[1];
        end else if (bus.redirect_valid) begin
            hp <= bus.redirect_pc[1];
        end else if (consume) begin
            hp <= hp ^ cmp;
        end
    end
`else
    logic unused_straddle;

    assign avail           = count != '0;
    assign cmp             = 1'b0;
    assign word            = head;
    assign pop             = consume;
    assign redirect_target = {bus.redirect_pc[AW-1:2], 2'b00};
    assign pc_step         = AW'(4);
    assign unused_straddle = ^{head_next, bus.redirect_pc[1:0]};
`endif

    assign bus.instr_valid      = avail;
    assign bus.instruction      = avail ? word : NOOP;
    assign bus.instr_compressed = avail && cmp;
    assign bus.o_pc             = pc;

    // Request bookkeeping: outstanding count, discard count for flushed responses, next fetch address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            discard     <= '0;
            fetch_addr  <= {RESET_PC[AW-1:2], 2'b00};
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(bus.mem_rsp_valid);
            if (bus.redirect_valid) begin
                discard    <= outstanding + CW'(req_fire) - CW'(bus.mem_rsp_valid);
                fetch_addr <= {bus.redirect_pc[AW-1:2], 2'b00};
            end else begin
                if (bus.mem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
                if (req_fire) fetch_addr <= fetch_addr + AW'(4);
            end
        end
    end

    // Program counter of the instruction presented to decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc <= redirect_target;
        end else if (consume) begin
            pc <= pc + pc_step;
        end
    end

endmodule
